// File: rtl/can_rec_uplink_scheduler_pkg.sv
// can_rec_uplink_scheduler_pkg: shared types and widths for the CAN receive uplink scheduler.
package mopshub_sched_pkg;
  localparam int FRAME_W = 76;
  localparam int BUS_IDX_W = 5;
  typedef enum logic [2:0] {IDLE, SELECT, WAIT_DATA, REQ, RELEASE} sched_state_t;
endpackage

// File: rtl/can_rec_uplink_scheduler_if.sv
// can_rec_uplink_if: request, receive-mux and e-link uplink signals of the scheduler.
interface can_rec_uplink_if
  import mopshub_sched_pkg::*;
#(
  parameter int N_CH = 32
);
  logic                 enable;
  logic [BUS_IDX_W-1:0] n_buses;
  logic [N_CH-1:0]      irq_can_rec;
  logic [FRAME_W-1:0]   data_rec_in;
  logic                 uplink_ack;
  logic [BUS_IDX_W-1:0] can_rec_select;
  logic [FRAME_W-1:0]   data_rec_uplink;
  logic                 uplink_req;
  logic [N_CH-1:0]      rec_done;
  logic                 busy;
  logic [7:0]           overrun_cnt;
  logic [7:0]           timeout_cnt;
  modport master (
    input  enable, n_buses, irq_can_rec, data_rec_in, uplink_ack,
    output can_rec_select, data_rec_uplink, uplink_req, rec_done, busy, overrun_cnt, timeout_cnt
  );
  modport slave (
    output enable, n_buses, irq_can_rec, data_rec_in, uplink_ack,
    input  can_rec_select, data_rec_uplink, uplink_req, rec_done, busy, overrun_cnt, timeout_cnt
  );
endinterface

// File: rtl/can_rec_uplink_scheduler_pick.sv
// rr_priority_pick: first pending bus searching upward from i_start+1, wrapping at i_n_buses.
module rr_priority_pick
  import mopshub_sched_pkg::*;
#(
  parameter int N_CH = 32
) (
  input  logic [N_CH-1:0]      i_pending,
  input  logic [BUS_IDX_W-1:0] i_start,
  input  logic [BUS_IDX_W-1:0] i_n_buses,
  output logic [BUS_IDX_W-1:0] o_winner,
  output logic                 o_valid
);
  logic [31:0]          w_pend;
  logic [BUS_IDX_W-1:0] w_first;
  logic [5:0]           w_idx;
  assign w_pend = 32'(i_pending);
  // a stale last grant above the current range restarts the search at bus 0
  assign w_first = i_start >= i_n_buses ? '0 : i_start + 5'd1;
  always_comb begin
    o_winner = '0;
    o_valid = 1'b0;
    w_idx = '0;
    for (int k = 31; k >= 0; k--) begin
      w_idx = 6'(w_first) + 6'(k);
      w_idx = w_idx > 6'(i_n_buses) ? w_idx - 6'(i_n_buses) - 6'd1 : w_idx;
      if (6'(k) <= 6'(i_n_buses) && w_pend[w_idx[4:0]]) begin
        o_valid = 1'b1;
        o_winner = w_idx[4:0];
      end
    end
  end
endmodule

// File: rtl/can_rec_uplink_scheduler.sv
// can_rec_uplink_scheduler: round-robin sharing of the 76-bit CAN receive uplink among up to 32 buses.
// Define CAN_REC_TIMEOUT_EN to drop frames the e-link packer never acknowledges.
module can_rec_uplink_scheduler
  import mopshub_sched_pkg::*;
#(
  parameter int          N_CH    = 32,
  parameter int          RD_LAT  = 2,
  parameter logic [15:0] TIMEOUT = 16'd4000
) (
  input logic clk,
  input logic rst,
  can_rec_uplink_if.master bus
);
  localparam logic [N_CH-1:0] ONE = 1;
  localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);
  sched_state_t         r_state;
  logic [N_CH-1:0]      r_pending, w_mask, w_set, w_clr, w_sel_oh, w_lost;
  logic [BUS_IDX_W-1:0] r_last, r_sel, w_win;
  logic [FRAME_W-1:0]   r_data;
  logic [2:0]           r_lat;
  logic [7:0]           r_ovr;
  logic [8:0]           w_ovr_sum;
  logic                 r_req, w_valid, w_timeout;
  for (genvar i = 0; i < N_CH; i++) begin : g_mask
    assign w_mask[i] = 5'(i) <= bus.n_buses;
  end
  assign w_set = bus.irq_can_rec & w_mask;
  assign w_sel_oh = ONE << r_sel;
  // IDLE also flushes requests left above a lowered n_buses
  assign w_clr = (r_state == RELEASE ? w_sel_oh : '0) | (r_state == IDLE ? ~w_mask : '0);
  assign w_lost = w_set & r_pending & ~w_clr;
  assign w_ovr_sum = {1'b0, r_ovr} + 9'($countones(w_lost));
  rr_priority_pick #(.N_CH(N_CH)) u_pick (
    .i_pending(r_pending & w_mask),
    .i_start  (r_last),
    .i_n_buses(bus.n_buses),
    .o_winner (w_win),
    .o_valid  (w_valid)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_pending <= '0;
      r_last <= 5'(N_CH - 1);
      r_sel <= '0;
      r_data <= '0;
      r_lat <= '0;
      r_req <= 1'b0;
      r_ovr <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_set;
      r_ovr <= w_ovr_sum[8] ? 8'hFF : w_ovr_sum[7:0];
      case (r_state)
        IDLE: if (bus.enable && w_valid) r_state <= SELECT;
        SELECT: begin
          if (w_valid) begin
            r_sel <= w_win;
            r_last <= w_win;
          end
          r_lat <= '0;
          r_state <= w_valid ? WAIT_DATA : IDLE;
        end
        WAIT_DATA: begin
          r_lat <= r_lat + 3'd1;
          if (r_lat == LAT_LAST) begin
            r_data <= bus.data_rec_in;
            r_req <= 1'b1;
            r_state <= REQ;
          end
        end
        REQ: if (bus.uplink_ack || w_timeout) begin
          r_req <= 1'b0;
          r_state <= RELEASE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef CAN_REC_TIMEOUT_EN
  logic [15:0] r_tcnt;
  logic [7:0]  r_to;
  assign w_timeout = r_state == REQ && !bus.uplink_ack && r_tcnt == TIMEOUT - 16'd1;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tcnt <= '0;
      r_to <= '0;
    end else begin
      r_tcnt <= r_state == REQ ? r_tcnt + 16'd1 : '0;
      r_to <= r_to + 8'(w_timeout && r_to != 8'hFF);
    end
  end
  assign bus.timeout_cnt = r_to;
`else
  assign w_timeout = 1'b0;
  assign bus.timeout_cnt = '0;
`endif
  assign bus.can_rec_select = r_sel;
  assign bus.data_rec_uplink = r_data;
  assign bus.uplink_req = r_req;
  assign bus.rec_done = r_state == RELEASE ? w_sel_oh : '0;
  assign bus.busy = r_state != IDLE;
  assign bus.overrun_cnt = r_ovr;
endmodule

// File: doc/can_rec_uplink_scheduler.md
Name: can_rec_uplink_scheduler

Overview:
- Round-robin scheduler that shares the single 76-bit uplink path (CAN receive → e-link TX) among up to 32 CAN bus receive channels.
- Latches per-bus frame-ready requests and drives can_rec_select to steer the external receive mux.
- Captures the selected 76-bit frame and hands it to the e-link serializer with a req/ack handshake.
- Sits between the 32 bus receive controllers and the uplink e-link packer inside mopshub_top.

Parameters:
- N_CH, 32, number of physical CAN channels (1..32).
- RD_LAT, 2, cycles from can_rec_select change to valid data_rec_in (1..7).
- TIMEOUT, 16'd4000, clk cycles allowed for uplink_ack before the frame is dropped (used only with the optional feature).

Ports:
- clk  in  1  system clock (40 MHz domain).
- rst  in  1  asynchronous active-low reset.
- enable  in  1  scheduler enable; low blocks new grants but does not abort a transfer in flight.
- n_buses  in  5  highest enabled bus index; requests from buses > n_buses are ignored.
- irq_can_rec  in  N_CH  one-cycle frame-ready pulse per bus.
- data_rec_in  in  76  muxed frame from the selected bus.
- uplink_ack  in  1  e-link packer accepted data_rec_uplink.
- can_rec_select  out  5  index of the bus being serviced.
- data_rec_uplink  out  76  captured frame.
- uplink_req  out  1  frame valid toward e-link, held until ack.
- rec_done  out  N_CH  one-hot one-cycle pulse: frame of that bus consumed.
- busy  out  1  high in any state other than IDLE.
- overrun_cnt  out  8  saturating count of requests lost because pending was already set.
- timeout_cnt  out  8  saturating count of dropped frames (feature only, else tied 0).

Behaviour:
- Reset (rst=0, async): state IDLE, pending=0, last_grant=N_CH-1, can_rec_select=0, data_rec_uplink=0, uplink_req=0, rec_done=0, busy=0, overrun_cnt=0, timeout_cnt=0.
- pending[i] is set on irq_can_rec[i] when i<=n_buses.
- pending[i] is cleared in RELEASE for the granted bus; if set and clear coincide on the same bus, the set wins and the bus remains pending.
- irq on a bus whose pending bit is already set (and which is not being cleared that cycle) increments overrun_cnt, saturating at 8'hFF.
- Arbitration: the first pending index searching upward from last_grant+1, wrapping modulo (n_buses+1). If last_grant>n_buses (n_buses was lowered), the search starts at 0.
- FSM:
  - IDLE: if enable && |pending_masked → SELECT, busy=1.
  - SELECT (1 cycle): load can_rec_select=winner, last_grant=winner, reset latency counter.
  - WAIT_DATA: count RD_LAT cycles; on the last one, data_rec_uplink<=data_rec_in and go to REQ.
  - REQ: uplink_req=1 and data held stable; on uplink_ack → RELEASE (uplink_req drops the same edge).
  - RELEASE (1 cycle): rec_done[winner]=1, clear pending[winner] → IDLE.
- Grant-to-uplink_req latency is 1+RD_LAT cycles; minimum back-to-back period is RD_LAT+4 cycles.
- uplink_ack outside REQ is ignored.
- can_rec_select holds its value in IDLE, so the mux does not glitch.
- Lowering n_buses mid-transfer: the current transfer completes; pending bits above the new n_buses are cleared in IDLE.

Optional Feature:
- Macro: CAN_REC_TIMEOUT_EN.
- With the macro: a 16-bit counter runs in REQ. On reaching TIMEOUT without ack, drop uplink_req, increment timeout_cnt (saturating), go to RELEASE (rec_done still pulses, so the channel frees its buffer).
- Without the macro: REQ waits indefinitely and timeout_cnt is constant 0.

Decomposition:
- Package mopshub_sched_pkg: enum sched_state_t {IDLE, SELECT, WAIT_DATA, REQ, RELEASE}; localparam FRAME_W=76; localparam BUS_IDX_W=5.
- One sub-module: rr_priority_pick. Combinational; inputs pending vector, start index, n_buses; outputs winner index and valid.

Test Plan:
- Single request: pulse irq_can_rec[3], data_rec_in=76'hABC.
  - can_rec_select=3 at cycle 2; uplink_req at cycle 2+RD_LAT with data 76'hABC.
  - ack → rec_done=32'h8 next cycle.
- Fairness: irq on buses 0, 5 and 31 at the same cycle, last_grant=31 → service order 0, 5, 31.
  - Re-pulse bus 0 during service of 5 → order 0, 5, 31, 0.
- n_buses=5'd7, pulse irq_can_rec[12] → no grant, busy stays 0, overrun_cnt=0.
- Overrun: hold uplink_ack=0, pulse irq_can_rec[2] three times → overrun_cnt=2, exactly one frame delivered after ack.
- Timeout (CAN_REC_TIMEOUT_EN, TIMEOUT=16): never ack → uplink_req falls after 16 cycles in REQ, timeout_cnt=1, rec_done pulses.
- Reset mid-REQ: rst low for 1 cycle → uplink_req=0 immediately (asynchronous), pending=0, state IDLE, the pre-reset request is not serviced.
